// File: rtl/magia_noc_rsp_meta_buffer_pkg.sv
// Shared types and sizing for the NoC egress response metadata buffer.
package magia_noc_rsp_meta_buffer_pkg;

  // NoC-side AXI ID width and local (L2-side) AXI ID width.
  localparam int AXI_NOC_ID_W = 4;
  localparam int L2_ID_W      = 2;

  // Source/destination node identifier carried in the NoC header.
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       port_id;
  } id_t;

  typedef logic [AXI_NOC_ID_W-1:0] axi_data_slv_id_t;
  typedef logic [0:0]              rob_idx_t;

  // One slot per local ID; each slot tracks up to 2**MetaCntW-1 outstanding bursts.
  localparam int MetaNumSlots = 2**L2_ID_W;
  localparam int MetaCntW     = 4;

  // Metadata restored on the response path.
  typedef struct packed {
    axi_data_slv_id_t in_id;
    id_t              src_id;
    rob_idx_t         rob_idx;
  } meta_t;

endpackage

// File: rtl/magia_noc_rsp_meta_buffer.sv
// Compresses wide NoC AXI IDs plus source node into a narrow local ID (one per
// slot), and restores the original ID, destination and rob_idx on responses.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; the request path only offers valid/ready when a target slot exists, and
// the response path is a pure pass-through of valid/ready.
module magia_noc_rsp_meta_buffer
  import magia_noc_rsp_meta_buffer_pkg::*;
#(
  parameter int InIdW   = AXI_NOC_ID_W,
  parameter int OutIdW  = L2_ID_W,
  parameter int NodeIdW = $bits(id_t),
  parameter int RobIdxW = 1,
  parameter int CntW    = MetaCntW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [InIdW-1:0]   req_in_id_i,
  input  logic [NodeIdW-1:0] req_src_id_i,
  input  logic [RobIdxW-1:0] req_rob_idx_i,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [OutIdW-1:0]  req_out_id_o,
  input  logic               rsp_valid_i,
  output logic               rsp_ready_o,
  input  logic [OutIdW-1:0]  rsp_out_id_i,
  input  logic               rsp_last_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [InIdW-1:0]   rsp_in_id_o,
  output logic [NodeIdW-1:0] rsp_dst_id_o,
  output logic [RobIdxW-1:0] rsp_rob_idx_o,
  output logic [OutIdW:0]    num_outstanding_o,
  output logic               err_o
);

  localparam int              NumSlots = 2**OutIdW;
  localparam logic [CntW-1:0] CntMax   = '1;

  logic [NumSlots-1:0] valid_q, valid_d;
  logic [InIdW-1:0]    in_id_q  [NumSlots];
  logic [InIdW-1:0]    in_id_d  [NumSlots];
  logic [NodeIdW-1:0]  src_id_q [NumSlots];
  logic [NodeIdW-1:0]  src_id_d [NumSlots];
  logic [RobIdxW-1:0]  rob_q    [NumSlots];
  logic [RobIdxW-1:0]  rob_d    [NumSlots];
  logic [CntW-1:0]     cnt_q    [NumSlots];
  logic [CntW-1:0]     cnt_d    [NumSlots];
  logic                err_q, err_d;
  logic [OutIdW:0]     num_q, num_d;

  logic                match_found, free_found, stall;
  logic [OutIdW-1:0]   match_idx, free_idx, target;
  logic                req_fire, rsp_fire, rsp_hits_free;
  logic [NumSlots-1:0] inc_vec, dec_vec;

  // Find the (unique) matching slot and the lowest-index free slot; the
  // descending loop lets the lowest index win for the free search.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid_q[i] && (in_id_q[i] == req_in_id_i) && (src_id_q[i] == req_src_id_i)) begin
        match_found = 1'b1;
        match_idx   = OutIdW'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = OutIdW'(i);
      end
    end
  end

  // Stall is a function of registered state and request fields only.
  assign stall  = match_found ? (cnt_q[match_idx] == CntMax) : !free_found;
  assign target = match_found ? match_idx : free_idx;

  assign req_valid_o  = req_valid_i & ~stall;
  assign req_ready_o  = req_ready_i & ~stall;
  assign req_out_id_o = target;

  assign rsp_valid_o   = rsp_valid_i;
  assign rsp_ready_o   = rsp_ready_i;
  assign rsp_in_id_o   = in_id_q[rsp_out_id_i];
  assign rsp_dst_id_o  = src_id_q[rsp_out_id_i];
  assign rsp_rob_idx_o = rob_q[rsp_out_id_i];

  assign num_outstanding_o = num_q;
  assign err_o             = err_q;

  assign req_fire      = req_valid_i & req_ready_o;
  assign rsp_fire      = rsp_valid_i & rsp_ready_i;
  assign rsp_hits_free = ~valid_q[rsp_out_id_i];

  // Per-slot increment/decrement events; responses to free slots never decrement.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NumSlots; i++) begin
      inc_vec[i] = req_fire && (target == OutIdW'(i));
      dec_vec[i] = rsp_fire && rsp_last_i && (rsp_out_id_i == OutIdW'(i)) && valid_q[i];
    end
  end

  // Next slot state: counters move by +1/-1, allocation stores metadata, and
  // the valid bit and slot count follow the new counter values.
  always_comb begin
    valid_d = '0;
    num_d   = '0;
    err_d   = err_q | (rsp_fire & rsp_hits_free);
    for (int i = 0; i < NumSlots; i++) begin
      in_id_d[i]  = in_id_q[i];
      src_id_d[i] = src_id_q[i];
      rob_d[i]    = rob_q[i];
      cnt_d[i]    = cnt_q[i] + CntW'(inc_vec[i]) - CntW'(dec_vec[i]);
      if (inc_vec[i] && !valid_q[i]) begin
        in_id_d[i]  = req_in_id_i;
        src_id_d[i] = req_src_id_i;
        rob_d[i]    = req_rob_idx_i;
      end
      valid_d[i] = (cnt_d[i] != '0);
      num_d      = num_d + (OutIdW + 1)'(valid_d[i]);
    end
  end

  // Slot registers; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      num_q   <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        in_id_q[i]  <= '0;
        src_id_q[i] <= '0;
        rob_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      num_q   <= num_d;
      for (int i = 0; i < NumSlots; i++) begin
        in_id_q[i]  <= in_id_d[i];
        src_id_q[i] <= src_id_d[i];
        rob_q[i]    <= rob_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Flag responses that arrive for a local ID with nothing outstanding.
  rsp_to_free_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_fire && rsp_hits_free))
    else $warning("response for unallocated local id %0d", rsp_out_id_i);

endmodule
